settings_writer: RTL and testbench



---
 rtl/settings_writer_if.sv | 31 +++
 rtl/settings_writer.sv | 130 +++++++++++++
 tb/tb_settings_writer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/settings_writer_if.sv
// Stream and bank-write signal bundle for settings_writer.
// master drives the field stream; slave is the writer itself.
interface settings_writer_if;
  logic        cmd_start;
  logic        num_valid;
  logic [31:0] num_data;
  logic        num_ready;
  logic        wr_en;
  logic [31:0] set_max_row;
  logic [31:0] set_max_col;
  logic [31:0] data_min;
  logic [31:0] data_max;
  logic [31:0] set_countdown_time;
  logic        busy;
  logic [2:0]  field_idx;
  logic        done;
  logic        err;
  logic [2:0]  err_code;

  modport master (
    output cmd_start, num_valid, num_data,
    input  num_ready, wr_en, set_max_row, set_max_col, data_min, data_max,
           set_countdown_time, busy, field_idx, done, err, err_code
  );

  modport slave (
    input  cmd_start, num_valid, num_data,
    output num_ready, wr_en, set_max_row, set_max_col, data_min, data_max,
           set_countdown_time, busy, field_idx, done, err, err_code
  );
endinterface

// File: rtl/settings_writer.sv
// Collects five setting fields, range-checks them together and strobes the bank on success.
// Optional idle-abort between fields: define SETTINGS_WRITER_TIMEOUT_EN.
module settings_writer #(
  parameter int unsigned MAX_DIM = 6,
  parameter int unsigned CD_MIN  = 5,
  parameter int unsigned CD_MAX  = 15
`ifdef SETTINGS_WRITER_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
`endif
) (
  input logic              clk,
  input logic              rst_n,
  settings_writer_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StCollect, StCheck, StCommit, StError} state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic [31:0] row_q, col_q, min_q, max_q, cd_q;
  logic        wr_en_q;
  logic        err_q;
  logic [2:0]  code_q;
  logic [2:0]  chk_code;
  logic        hs;

`ifdef SETTINGS_WRITER_TIMEOUT_EN
  logic [31:0] tmo_q;
`endif

  assign hs = (state_q == StCollect) && bus.num_valid;

  // Rules are applied highest code first so the lowest failing code survives.
  always_comb begin
    chk_code = 3'd0;
    if (cd_q < CD_MIN || cd_q > CD_MAX)   chk_code = 3'd4;
    if ($signed(min_q) > $signed(max_q))  chk_code = 3'd3;
    if (col_q == 32'd0 || col_q > MAX_DIM) chk_code = 3'd2;
    if (row_q == 32'd0 || row_q > MAX_DIM) chk_code = 3'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 3'd0;
      row_q   <= 32'd0;
      col_q   <= 32'd0;
      min_q   <= 32'd0;
      max_q   <= 32'd0;
      cd_q    <= 32'd0;
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= 3'd0;
`ifdef SETTINGS_WRITER_TIMEOUT_EN
      tmo_q   <= 32'd0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.cmd_start) begin
            state_q <= StCollect;
            idx_q   <= 3'd0;
            code_q  <= 3'd0;
`ifdef SETTINGS_WRITER_TIMEOUT_EN
            tmo_q   <= 32'd0;
`endif
          end
        end
        StCollect: begin
          if (bus.cmd_start) begin
            // Restart wins over a same-cycle handshake.
            idx_q <= 3'd0;
`ifdef SETTINGS_WRITER_TIMEOUT_EN
            tmo_q <= 32'd0;
`endif
          end else if (hs) begin
            case (idx_q)
              3'd0:    row_q <= bus.num_data;
              3'd1:    col_q <= bus.num_data;
              3'd2:    min_q <= bus.num_data;
              3'd3:    max_q <= bus.num_data;
              default: cd_q  <= bus.num_data;
            endcase
            idx_q <= idx_q + 3'd1;
            if (idx_q == 3'd4) state_q <= StCheck;
`ifdef SETTINGS_WRITER_TIMEOUT_EN
            tmo_q <= 32'd0;
          end else if (tmo_q == TIMEOUT_CYCLES - 1) begin
            state_q <= StError;
            err_q   <= 1'b1;
            code_q  <= 3'd5;
          end else begin
            tmo_q <= tmo_q + 32'd1;
`endif
          end
        end
        StCheck: begin
          if (chk_code == 3'd0) begin
            state_q <= StCommit;
            wr_en_q <= 1'b1;
          end else begin
            state_q <= StError;
            err_q   <= 1'b1;
            code_q  <= chk_code;
          end
        end
        StCommit: state_q <= StIdle;
        StError:  state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

  assign bus.num_ready          = (state_q == StCollect);
  assign bus.busy               = (state_q != StIdle);
  assign bus.wr_en              = wr_en_q;
  assign bus.done               = wr_en_q;
  assign bus.err                = err_q;
  assign bus.err_code           = code_q;
  assign bus.field_idx          = idx_q;
  assign bus.set_max_row        = row_q;
  assign bus.set_max_col        = col_q;
  assign bus.data_min           = min_q;
  assign bus.data_max           = max_q;
  assign bus.set_countdown_time = cd_q;

endmodule

// File: tb/tb_settings_writer.sv
// Scoreboard bench for settings_writer: sessions push expected outcomes, a monitor pops them.
module tb_settings_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  settings_writer_if bus ();

`ifdef SETTINGS_WRITER_TIMEOUT_EN
  settings_writer #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
  settings_writer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  typedef struct packed {
    logic [2:0]  code;
    logic [31:0] row, col, mn, mx, cd;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] code, input logic [31:0] row, col, mn, mx, cd);
    exp_t e;
    e.code = code; e.row = row; e.col = col; e.mn = mn; e.mx = mx; e.cd = cd;
    return e;
  endfunction

  // Monitor: every wr_en or err pulse must match the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.wr_en || bus.err) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_event: wr_en=%0b err=%0b with nothing expected",
                   bus.wr_en, bus.err);
        end else begin
          e = exp_q.pop_front();
          check("done_eq_wr_en", {31'd0, bus.done}, {31'd0, bus.wr_en});
          if (e.code == 3'd0) begin
            check("commit_wr_en", {31'd0, bus.wr_en}, 32'd1);
            check("commit_err", {31'd0, bus.err}, 32'd0);
            check("set_max_row", bus.set_max_row, e.row);
            check("set_max_col", bus.set_max_col, e.col);
            check("data_min", bus.data_min, e.mn);
            check("data_max", bus.data_max, e.mx);
            check("set_countdown_time", bus.set_countdown_time, e.cd);
          end else begin
            check("reject_err", {31'd0, bus.err}, 32'd1);
            check("reject_wr_en", {31'd0, bus.wr_en}, 32'd0);
            check("err_code", {29'd0, bus.err_code}, {29'd0, e.code});
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    bus.cmd_start = 1'b1;
    tick();
    bus.cmd_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] v);
    bit ok;
    ok = 1'b0;
    bus.num_valid = 1'b1;
    bus.num_data  = v;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.num_ready;
      tick();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout: num_ready=0, expected 1 within 20 cycles");
    end
  endtask

  task automatic session(input logic [31:0] a, b, c, d, e, input logic [2:0] code);
    exp_q.push_back(mk(code, a, b, c, d, e));
    start();
    send(a); send(b); send(c); send(d); send(e);
    bus.num_valid = 1'b0;
    repeat (4) tick();
  endtask

  initial begin
    bus.cmd_start = 1'b0;
    bus.num_valid = 1'b0;
    bus.num_data  = 32'd0;

    #2;
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst_set_max_row", bus.set_max_row, 32'd0);
    check("rst_data_max", bus.data_max, 32'd0);
    check("rst_field_idx", {29'd0, bus.field_idx}, 32'd0);
    check("rst_err_code", {29'd0, bus.err_code}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Legal session with valid held high, plus latency checks.
    exp_q.push_back(mk(3'd0, 32'd4, 32'd3, 32'hFFFF_FFFE, 32'd7, 32'd10));
    start();
    send(32'd4); send(32'd3); send(32'hFFFF_FFFE); send(32'd7); send(32'd10);
    bus.num_valid = 1'b0;
    check("check_cycle_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("check_cycle_busy", {31'd0, bus.busy}, 32'd1);
    check("check_cycle_ready", {31'd0, bus.num_ready}, 32'd0);
    tick();
    check("commit_cycle_wr_en", {31'd0, bus.wr_en}, 32'd1);
    tick();
    check("after_commit_wr_en", {31'd0, bus.wr_en}, 32'd0);
    repeat (2) tick();
    check("idle_busy", {31'd0, bus.busy}, 32'd0);
    check("final_field_idx", {29'd0, bus.field_idx}, 32'd5);

    // Multiple violations: lowest code wins, and it is held afterwards.
    session(32'd0, 32'd9, 32'd8, 32'd2, 32'd20, 3'd1);
    check("err_code_held", {29'd0, bus.err_code}, 32'd1);
    check("rejected_raw_row", bus.set_max_row, 32'd0);

    // Signed compare.
    session(32'd2, 32'd2, 32'd5, 32'hFFFF_FFFF, 32'd5, 3'd3);
    session(32'd2, 32'd2, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'd5, 3'd0);

    // Boundaries of each range.
    session(32'd6, 32'd7, 32'd0, 32'd0, 32'd5, 3'd2);
    session(32'd6, 32'd1, 32'd3, 32'd3, 32'd16, 3'd4);
    session(32'd1, 32'd6, 32'd3, 32'd3, 32'd4, 3'd4);
    session(32'd6, 32'd1, 32'd3, 32'd3, 32'd15, 3'd0);

    // Flow control: valid pulses while idle are ignored.
    bus.num_valid = 1'b1;
    bus.num_data  = 32'd99;
    repeat (3) tick();
    check("idle_ready", {31'd0, bus.num_ready}, 32'd0);
    check("idle_no_capture", bus.set_max_row, 32'd6);
    bus.num_valid = 1'b0;
    tick();
    start();
    check("start_field_idx", {29'd0, bus.field_idx}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(32'd1);
      bus.num_valid = 1'b0;
      tick();
    end
    check("partial_field_idx", {29'd0, bus.field_idx}, 32'd3);
    exp_q.push_back(mk(3'd0, 32'd5, 32'd4, 32'd1, 32'd1, 32'd6));
    start();
    check("restart_field_idx", {29'd0, bus.field_idx}, 32'd0);
    begin
      logic [31:0] vals [5];
      vals = '{32'd5, 32'd4, 32'd1, 32'd1, 32'd6};
      for (int i = 0; i < 5; i++) begin
        send(vals[i]);
        bus.num_valid = 1'b0;
        check("toggle_field_idx", {29'd0, bus.field_idx}, i + 1);
        tick();
      end
    end
    repeat (4) tick();

    // Reset mid-session.
    start();
    send(32'd3); send(32'd3); send(32'd0); send(32'd0);
    bus.num_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("midrst_ready", {31'd0, bus.num_ready}, 32'd0);
    check("midrst_max_row", bus.set_max_row, 32'd0);
    check("midrst_data_min", bus.data_min, 32'd0);
    check("midrst_cd", bus.set_countdown_time, 32'd0);
    check("midrst_field_idx", {29'd0, bus.field_idx}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    session(32'd3, 32'd5, 32'hFFFF_FF00, 32'd100, 32'd12, 3'd0);

`ifdef SETTINGS_WRITER_TIMEOUT_EN
    exp_q.push_back(mk(3'd5, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0));
    start();
    send(32'd2); send(32'd2);
    bus.num_valid = 1'b0;
    repeat (25) tick();
    check("timeout_busy", {31'd0, bus.busy}, 32'd0);
    check("timeout_err_code", {29'd0, bus.err_code}, 32'd5);
`endif

    repeat (3) tick();
    check("pending_events", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
